// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtracter: one CHUNK-bit slice per cycle, LSB first, valid/ready on both sides.
// Define SEQ_ADDSUB_FLAGS_EN to register the ovf/zero flags; otherwise both ports read constant 0.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             last_slice;
  int unsigned      base;
  logic [CHUNK-1:0] a_s, b_s;
  logic [CHUNK:0]   s;
  logic [WIDTH-1:0] sum_next;

  assign in_ready   = rst_n && (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  // Subtraction is a + ~b + 1; STEP is zero-extended before inversion.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    b_eff   = b;
    cin_eff = 1'b0;
    case (op)
      2'b01: begin b_eff = ~b;              cin_eff = 1'b1; end
      2'b10: begin b_eff = WIDTH'(STEP);    cin_eff = 1'b0; end
      2'b11: begin b_eff = ~(WIDTH'(STEP)); cin_eff = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    base     = int'(cnt_q) * CHUNK;
    a_s      = a_q[base +: CHUNK];
    b_s      = b_q[base +: CHUNK];
    s        = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry_q};
    sum_next = result;
    sum_next[base +: CHUNK] = s[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: operand registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b_eff;
    end
  end

`ifdef SEQ_ADDSUB_FLAGS_EN
  logic c_msb;
  // Carry into the top bit recovered from the sum bit and its two addends.
  assign c_msb = s[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
`ifdef SEQ_ADDSUB_FLAGS_EN
      ovf     <= 1'b0;
      zero    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q   <= '0;
            carry_q <= cin_eff;
          end
        end
        RUN: begin
          result  <= sum_next;
          carry_q <= s[CHUNK];
          if (last_slice) begin
            cnt_q <= '0;
            cout  <= s[CHUNK];
`ifdef SEQ_ADDSUB_FLAGS_EN
            ovf   <= s[CHUNK] ^ c_msb;
            zero  <= (sum_next == '0);
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are positive multiples of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 8, bits processed per cycle by the internal carry-lookahead slice.
REQ-003 SHALL have parameter STEP, default 4, constant used by the INC/DEC ops.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port op  input  2  00 ADD, 01 SUB, 10 INC, 11 DEC.
REQ-009 SHALL have port a  input  WIDTH  first operand.
REQ-010 SHALL have port b  input  WIDTH  second operand; ignored for INC/DEC.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port result  output  WIDTH  sum/difference.
REQ-014 SHALL have port cout  output  1  carry out of MSB; for SUB/DEC 1 = no borrow.
REQ-015 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-016 SHALL have port zero  output  1  result == 0.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 SHALL accept a request on a rising edge with in_valid && in_ready, latching a, effective B operand and carry-in, then enter RUN; later input changes have no effect.
REQ-019 SHALL form effective B / carry-in: ADD b/0; SUB ~b/1; INC STEP/0; DEC ~STEP/1 (STEP zero-extended to WIDTH).
REQ-020 SHALL in RUN process one CHUNK slice per cycle, LSB slice first, carry held in a register between slices; slice counter runs 0..WIDTH/CHUNK-1.
REQ-021 SHALL enter DONE on the edge completing the last slice; out_valid rises exactly WIDTH/CHUNK edges after the acceptance edge.
REQ-022 SHALL hold result, cout, ovf, zero stable throughout DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-023 SHALL compute ovf as carry-into-MSB XOR carry-out-of-MSB.
REQ-024 SHALL ignore in_valid in RUN and DONE (no queuing, no corruption of the in-flight operation).
REQ-025 SHALL, when WIDTH == CHUNK, complete in one RUN cycle.
REQ-026 SHALL hold result/flags at their last values in IDLE (0 after reset).

Reset
REQ-027 SHALL on rst_n low immediately force state IDLE, slice counter 0, carry 0, result 0, cout 0, ovf 0, zero 0, out_valid 0; in_ready 1 once rst_n is high.
REQ-028 SHALL abort any operation in RUN or DONE on reset with no result delivered.

Configuration
REQ-029 SHALL, with macro SEQ_ADDSUB_FLAGS_EN defined, compute and register ovf and zero per REQ-016/REQ-023.
REQ-030 SHALL, without SEQ_ADDSUB_FLAGS_EN, keep the ovf and zero ports but drive them constant 0; result, cout and timing unchanged.

Verification (WIDTH=32, CHUNK=8, STEP=4, FLAGS_EN defined unless noted)
REQ-031 SHALL cover ADD a=0xFFFFFFFF b=1 -> result 0x00000000, cout 1, zero 1, ovf 0, out_valid exactly 4 edges after acceptance.
REQ-032 SHALL cover ADD 0x7FFFFFFF+1 -> 0x80000000, ovf 1, cout 0; SUB 5-7 -> 0xFFFFFFFE, cout 0; SUB 7-5 -> 0x00000002, cout 1.
REQ-033 SHALL cover INC a=0xFFFFFFFC -> 0x00000000, cout 1, zero 1; DEC a=0 -> 0xFFFFFFFC, cout 0.
REQ-034 SHALL cover out_ready low 10 cycles in DONE with in_valid pulses and changing a/b -> result/flags stable, in_ready 0, no extra results; single result delivered on out_ready.
REQ-035 SHALL cover rst_n low during RUN slice 2 -> all outputs 0 immediately, no out_valid; next request after release computes correctly.
REQ-036 SHALL cover build without SEQ_ADDSUB_FLAGS_EN repeating REQ-031 -> ovf 0, zero 0, result and cout identical.
